ctrl_step_sequencer: RTL and testbench
======================================

Name: ctrl_step_sequencer

Overview:
- Parametrised hardware control-step sequencer that generates the datapath strobes for fetch plus execute of register and immediate ALU instructions.
- It is the RTL successor of the hand-timed T0..T5 stimulus used in datapath benches.
- Sits beside `datapath`: it reads IR and drives every control input (`PCout`, `Zlowout`, `Gra`/`Grb`/`Grc`, `Rin`/`Rout`, `Cout`, `ctrl`, ...).
- Adds variable step length, memory wait states, halt/illegal detection and optional two-word mul/div writeback.

Parameters:
- OPCODE_W, 5: IR opcode field width, `ir[31 -: OPCODE_W]`.
- CTRL_W, 4: ALU `ctrl` width.
- STEP_CYCLES, 1: clocks each step is held, minimum 1 (range 1..15).

Ports:
- `Clock` in 1: sole clock, rising edge.
- `Clear` in 1: synchronous reset, active-low.
- `start` in 1: leave HALT and begin fetch.
- `ir` in 32: current IR contents from datapath.
- `mem_ready` in 1: memory read data valid.
- `PCout`, `Zlowout`, `Zhighout`, `MDRout`, `Rout`, `Cout` out 1 each: bus drive selects.
- `MARin`, `MDRin`, `IRin`, `Yin`, `Zlowin`, `Zhighin`, `PCin`, `Rin`, `LOin`, `HIin` out 1 each: register load strobes.
- `IncPC`, `Read`, `Gra`, `Grb`, `Grc` out 1 each: PC increment, memory read, register select.
- `ctrl` out CTRL_W: ALU operation.
- `step` out 4: current state code.
- `running` out 1: high outside HALT.
- `illegal` out 1: sticky illegal-opcode flag.

Behaviour:
- Reset: while `Clear`=0 at a clock edge, the state goes to HALT. All strobes, `ctrl`, `running` and `illegal` are 0, and the cycle counter is 0. Reset mid-step aborts the instruction; no partial strobes follow.
- Strobes are combinational from state plus latched opcode, and are asserted for every cycle of a step. Steps are single-pulse safe: repeated loads reload identical values.
- Step advance: the counter runs 0..STEP_CYCLES-1, and the step ends when the counter reaches STEP_CYCLES-1.
- T1 wait states: T1 also requires `mem_ready`=1. While `mem_ready`=0, T1 holds with the counter saturated, and `Read`/`MDRin` stay high.
- HALT: `start`=1 goes to T0, clears `illegal` and sets `running`.
- T0: `PCout`, `MARin`, `IncPC`, `Zlowin`.
- T1: `Zlowout`, `PCin`, `Read`, `MDRin`.
- T2: `MDRout`, `IRin`. At the end of T2 the opcode is sampled from `ir` into an internal register (the IR value is visible on the following cycles).
- T3 decode for nop: go to T0.
- T3 decode for halt: go to HALT.
- T3 decode for an unknown opcode: go to HALT and set `illegal`.
- T3 for R and I types: `Grb`, `Rout`, `Yin`.
- T4, R-type: `Grc`, `Rout`, `ctrl`=op, `Zlowin`.
- T4, I-type: `Cout`, `ctrl`=op, `Zlowin`.
- T5: `Zlowout`, `Gra`, `Rin`, then go to T0.
- Step codes: HALT=0, T0..T6 = 1..7.
- ALU codes: AND=0, OR=1, ADD=2, SUB=3, MUL=4, DIV=5. andi/and=0, ori/or=1, addi/add=2, sub=3.
- Opcode map: add 00011, sub 00100, and 00101, or 00110, addi 01100, andi 01101, ori 01110, mul 01111, div 10000, nop 11010, halt 11011.
- `start` while running is ignored.

Optional Feature:
- Macro: `CTRL_SEQ_MULDIV_EN`.
- Defined: mul and div are legal.
  - T3: `Grb`, `Rout`, `Yin`.
  - T4: `Grc`, `Rout`, `ctrl`=4 or 5, `Zlowin`, `Zhighin`.
  - T5: `Zlowout`, `LOin`.
  - T6: `Zhighout`, `HIin`, then go to T0.
- Undefined: mul and div decode as illegal, T6 does not exist, and `LOin`/`HIin` are tied 0.

Decomposition:
- Package `ctrl_seq_pkg`: state enum, opcode constants, ALU ctrl constants, opcode-class function (R/I/MULDIV/NOP/HALT/ILLEGAL).
- One natural sub-module: `step_timer`, the STEP_CYCLES counter with the hold input (`mem_ready`) and the `done` output.

Test Plan:
- Reset plus andi: `Clear` low for 2 cycles, then `start`, `mem_ready`=1, STEP_CYCLES=1, `ir`=0x6A900000 (andi). Required: T0..T5 in six cycles; T4 has `Cout`=1, `ctrl`=0; T5 has `Gra`/`Rin`/`Zlowout`=1; then back to T0.
- Wait states: `mem_ready` held low for 3 cycles in T1. Required: T1 lasts 4 cycles with `Read`/`MDRin` high throughout; T2 follows the cycle after `mem_ready` rises.
- STEP_CYCLES=3 with add (opcode 00011). Required: each strobe high exactly 3 cycles; T4 has `ctrl`=2 and `Grc`=1; 18 cycles per instruction.
- Halt and illegal: opcode 11011 gives `step`=0 and `running`=0 after T3. Opcode 11111 additionally sets `illegal`=1. A `start` pulse clears `illegal` and gives `step`=1.
- Reset mid-T4: `Clear` low during T4. Required: the next cycle shows `step`=0 with all strobes 0 and no `Rin` pulse.
- mul with the macro defined: T5 has `LOin`, T6 has `Zhighout`+`HIin`, `step`=7. Without the macro, the same opcode gives `illegal`=1.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// Shared types for the control-step sequencer: step codes, opcode map, ALU codes, opcode classing.
// Optional two-word mul/div writeback is enabled by CTRL_SEQ_MULDIV_EN.
package ctrl_seq_pkg;

  typedef enum logic [3:0] {
    ST_HALT = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_MULDIV, CLS_NOP, CLS_HALT, CLS_ILL
  } op_class_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd3;
  localparam logic [3:0] ALU_MUL = 4'd4;
  localparam logic [3:0] ALU_DIV = 4'd5;

  function automatic op_class_t op_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: op_class = CLS_R;
      OP_ADDI, OP_ANDI, OP_ORI:      op_class = CLS_I;
`ifdef CTRL_SEQ_MULDIV_EN
      OP_MUL, OP_DIV:                op_class = CLS_MULDIV;
`endif
      OP_NOP:                        op_class = CLS_NOP;
      OP_HALT:                       op_class = CLS_HALT;
      default:                       op_class = CLS_ILL;
    endcase
  endfunction

  function automatic logic [3:0] alu_code(input logic [4:0] op);
    case (op)
      OP_AND, OP_ANDI: alu_code = ALU_AND;
      OP_OR, OP_ORI:   alu_code = ALU_OR;
      OP_ADD, OP_ADDI: alu_code = ALU_ADD;
      OP_SUB:          alu_code = ALU_SUB;
      OP_MUL:          alu_code = ALU_MUL;
      OP_DIV:          alu_code = ALU_DIV;
      default:         alu_code = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/step_timer.sv
// Holds each control step for STEP_CYCLES clocks; done pulses on the last cycle unless hold is high.
// While hold is high the count saturates at its last value and done stays low.
module step_timer #(
  parameter int STEP_CYCLES = 1
) (
  input  logic Clock,
  input  logic Clear,
  input  logic run,
  input  logic hold,
  output logic done
);

  localparam logic [3:0] LAST = 4'(STEP_CYCLES - 1);

  logic [3:0] cnt_q;

  assign done = run && (cnt_q == LAST) && !hold;

  always_ff @(posedge Clock) begin
    if (!Clear || !run || done) begin
      cnt_q <= '0;
    end else if (cnt_q != LAST) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

endmodule

// File: rtl/ctrl_step_sequencer.sv
// Fetch/execute control-step sequencer driving datapath strobes from state plus latched opcode.
// T1 stalls on mem_ready; define CTRL_SEQ_MULDIV_EN for mul/div with the extra HI writeback step.
module ctrl_step_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int OPCODE_W    = 5,
  parameter int CTRL_W      = 4,
  parameter int STEP_CYCLES = 1
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              start,
  input  logic [31:0]       ir,
  input  logic              mem_ready,
  output logic              PCout,
  output logic              Zlowout,
  output logic              Zhighout,
  output logic              MDRout,
  output logic              Rout,
  output logic              Cout,
  output logic              MARin,
  output logic              MDRin,
  output logic              IRin,
  output logic              Yin,
  output logic              Zlowin,
  output logic              Zhighin,
  output logic              PCin,
  output logic              Rin,
  output logic              LOin,
  output logic              HIin,
  output logic              IncPC,
  output logic              Read,
  output logic              Gra,
  output logic              Grb,
  output logic              Grc,
  output logic [CTRL_W-1:0] ctrl,
  output logic [3:0]        step,
  output logic              running,
  output logic              illegal
);

  state_t                state_q, state_d;
  logic [OPCODE_W-1:0]   op_q;
  logic [4:0]            op5;
  op_class_t             cls;
  logic                  illegal_q;
  logic                  done;
  logic                  hold;
  logic                  unused_ir;

  assign unused_ir = ^ir[31-OPCODE_W:0];
  assign op5       = op_q[OPCODE_W-1 -: 5];
  assign cls       = op_class(op5);
  assign hold      = (state_q == ST_T1) && !mem_ready;

  step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_step_timer (
    .Clock (Clock),
    .Clear (Clear),
    .run   (state_q != ST_HALT),
    .hold  (hold),
    .done  (done)
  );

  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state_q   <= ST_HALT;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_T2 && done) op_q <= ir[31 -: OPCODE_W];
      if (state_q == ST_HALT && start) illegal_q <= 1'b0;
      else if (state_q == ST_T3 && done && cls == CLS_ILL) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    PCout    = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0;
    Rout     = 1'b0; Cout    = 1'b0; MARin    = 1'b0; MDRin  = 1'b0;
    IRin     = 1'b0; Yin     = 1'b0; Zlowin   = 1'b0; Zhighin = 1'b0;
    PCin     = 1'b0; Rin     = 1'b0; LOin     = 1'b0; HIin   = 1'b0;
    IncPC    = 1'b0; Read    = 1'b0; Gra      = 1'b0; Grb    = 1'b0;
    Grc      = 1'b0;
    ctrl     = '0;
    case (state_q)
      ST_HALT: if (start) state_d = ST_T0;
      ST_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
        if (done) state_d = ST_T1;
      end
      ST_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        if (done) state_d = ST_T2;
      end
      ST_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        if (done) state_d = ST_T3;
      end
      ST_T3: begin
        if (cls inside {CLS_R, CLS_I, CLS_MULDIV}) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end
        if (done) begin
          case (cls)
            CLS_R, CLS_I, CLS_MULDIV: state_d = ST_T4;
            CLS_NOP:                  state_d = ST_T0;
            default:                  state_d = ST_HALT;
          endcase
        end
      end
      ST_T4: begin
        ctrl   = CTRL_W'(alu_code(op5));
        Zlowin = 1'b1;
        if (cls == CLS_I) Cout = 1'b1;
        else begin Grc = 1'b1; Rout = 1'b1; end
        if (cls == CLS_MULDIV) Zhighin = 1'b1;
        if (done) state_d = ST_T5;
      end
      ST_T5: begin
        Zlowout = 1'b1;
`ifdef CTRL_SEQ_MULDIV_EN
        if (cls == CLS_MULDIV) begin
          LOin = 1'b1;
          if (done) state_d = ST_T6;
        end else begin
          Gra = 1'b1; Rin = 1'b1;
          if (done) state_d = ST_T0;
        end
`else
        Gra = 1'b1; Rin = 1'b1;
        if (done) state_d = ST_T0;
`endif
      end
`ifdef CTRL_SEQ_MULDIV_EN
      ST_T6: begin
        Zhighout = 1'b1; HIin = 1'b1;
        if (done) state_d = ST_T0;
      end
`endif
      default: state_d = ST_HALT;
    endcase
  end

  assign step    = state_q;
  assign running = (state_q != ST_HALT);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_ctrl_step_sequencer.sv
// Directed bench for ctrl_step_sequencer: one instance at STEP_CYCLES=1, one at STEP_CYCLES=3.
// Expected per-cycle outputs are queued with each stimulus step and popped when the cycle is observed.
module tb_ctrl_step_sequencer;

  localparam logic [31:0] IR_ANDI = 32'h6A900000;
  localparam logic [31:0] IR_ADD  = 32'h18000000;
  localparam logic [31:0] IR_OR   = 32'h30000000;
  localparam logic [31:0] IR_MUL  = 32'h78000000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;
  localparam logic [31:0] IR_ILL  = 32'hF8000000;

  // Strobe vector bit order: 0 PCout,1 Zlowout,2 Zhighout,3 MDRout,4 Rout,5 Cout,6 MARin,
  // 7 MDRin,8 IRin,9 Yin,10 Zlowin,11 Zhighin,12 PCin,13 Rin,14 LOin,15 HIin,16 IncPC,
  // 17 Read,18 Gra,19 Grb,20 Grc
  localparam logic [20:0] E_0   = 21'd0;
  localparam logic [20:0] E_T0  = (21'd1 << 0) | (21'd1 << 6) | (21'd1 << 10) | (21'd1 << 16);
  localparam logic [20:0] E_T1  = (21'd1 << 1) | (21'd1 << 12) | (21'd1 << 17) | (21'd1 << 7);
  localparam logic [20:0] E_T2  = (21'd1 << 3) | (21'd1 << 8);
  localparam logic [20:0] E_T3  = (21'd1 << 19) | (21'd1 << 4) | (21'd1 << 9);
  localparam logic [20:0] E_T4R = (21'd1 << 20) | (21'd1 << 4) | (21'd1 << 10);
  localparam logic [20:0] E_T4I = (21'd1 << 5) | (21'd1 << 10);
  localparam logic [20:0] E_T5  = (21'd1 << 1) | (21'd1 << 18) | (21'd1 << 13);
  localparam logic [20:0] E_T4M = (21'd1 << 20) | (21'd1 << 4) | (21'd1 << 10) | (21'd1 << 11);
  localparam logic [20:0] E_T5M = (21'd1 << 1) | (21'd1 << 14);
  localparam logic [20:0] E_T6  = (21'd1 << 2) | (21'd1 << 15);

  typedef struct packed {
    logic [3:0]  st;
    logic [20:0] sb;
    logic [3:0]  c;
    logic        run;
    logic        ill;
  } exp_t;

  logic        Clock = 1'b0;
  logic        Clear;
  logic        mem_ready;
  logic [31:0] ir;
  logic        start_v   [2];
  logic [20:0] strb      [2];
  logic [3:0]  ctrl_o    [2];
  logic [3:0]  step_o    [2];
  logic        running_o [2];
  logic        illegal_o [2];

  exp_t  sbq[$];
  string tagq[$];
  int    checks = 0;
  int    errors = 0;

  always #5 Clock = ~Clock;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic pc_o, zl_o, zh_o, mdr_o, r_o, c_o, mar_i, mdr_i, ir_i, y_i, zl_i;
    logic zh_i, pc_i, r_i, lo_i, hi_i, inc, rd, ga, gb, gc;
    ctrl_step_sequencer #(.OPCODE_W(5), .CTRL_W(4), .STEP_CYCLES(g == 0 ? 1 : 3)) u_dut (
      .Clock(Clock), .Clear(Clear), .start(start_v[g]), .ir(ir), .mem_ready(mem_ready),
      .PCout(pc_o), .Zlowout(zl_o), .Zhighout(zh_o), .MDRout(mdr_o), .Rout(r_o), .Cout(c_o),
      .MARin(mar_i), .MDRin(mdr_i), .IRin(ir_i), .Yin(y_i), .Zlowin(zl_i), .Zhighin(zh_i),
      .PCin(pc_i), .Rin(r_i), .LOin(lo_i), .HIin(hi_i), .IncPC(inc), .Read(rd),
      .Gra(ga), .Grb(gb), .Grc(gc), .ctrl(ctrl_o[g]), .step(step_o[g]),
      .running(running_o[g]), .illegal(illegal_o[g])
    );
    assign strb[g] = {gc, gb, ga, rd, inc, hi_i, lo_i, r_i, pc_i, zh_i, zl_i,
                      y_i, ir_i, mdr_i, mar_i, c_o, r_o, mdr_o, zh_o, zl_o, pc_o};
  end

  // Queue the expected outcome of the next edge, clock it, then pop and compare.
  task automatic expect_next(input int d, input string tag, input logic [3:0] st,
                             input logic [20:0] sb, input logic [3:0] c, input logic ill);
    exp_t  e;
    string t;
    sbq.push_back('{st: st, sb: sb, c: c, run: (st != 4'd0), ill: ill});
    tagq.push_back(tag);
    @(posedge Clock);
    #1;
    e = sbq.pop_front();
    t = tagq.pop_front();
    checks++;
    assert (step_o[d] === e.st) else begin
      errors++; $error("FAIL %s step: observed %0d expected %0d", t, step_o[d], e.st);
    end
    checks++;
    assert (strb[d] === e.sb) else begin
      errors++; $error("FAIL %s strobes: observed %h expected %h", t, strb[d], e.sb);
    end
    checks++;
    assert (ctrl_o[d] === e.c) else begin
      errors++; $error("FAIL %s ctrl: observed %0d expected %0d", t, ctrl_o[d], e.c);
    end
    checks++;
    assert (running_o[d] === e.run) else begin
      errors++; $error("FAIL %s running: observed %b expected %b", t, running_o[d], e.run);
    end
    checks++;
    assert (illegal_o[d] === e.ill) else begin
      errors++; $error("FAIL %s illegal: observed %b expected %b", t, illegal_o[d], e.ill);
    end
  endtask

  initial begin
    logic [3:0]  st3 [6];
    logic [20:0] sb3 [6];
    logic [3:0]  c3  [6];
    st3 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    sb3 = '{E_T0, E_T1, E_T2, E_T3, E_T4R, E_T5};
    c3  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd0};

    Clear = 1'b0; mem_ready = 1'b1; ir = IR_ANDI;
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    expect_next(0, "rst_a", 4'd0, E_0, 4'd0, 1'b0);
    expect_next(1, "rst_b", 4'd0, E_0, 4'd0, 1'b0);

    // andi at one clock per step
    Clear = 1'b1; start_v[0] = 1'b1;
    expect_next(0, "andi_t0", 4'd1, E_T0, 4'd0, 1'b0);
    start_v[0] = 1'b0;
    expect_next(0, "andi_t1", 4'd2, E_T1, 4'd0, 1'b0);
    expect_next(0, "andi_t2", 4'd3, E_T2, 4'd0, 1'b0);
    expect_next(0, "andi_t3", 4'd4, E_T3, 4'd0, 1'b0);
    expect_next(0, "andi_t4", 4'd5, E_T4I, 4'd0, 1'b0);
    expect_next(0, "andi_t5", 4'd6, E_T5, 4'd0, 1'b0);
    expect_next(0, "andi_t0b", 4'd1, E_T0, 4'd0, 1'b0);

    // wait states in T1, add; start while running must be ignored
    mem_ready = 1'b0; ir = IR_ADD; start_v[0] = 1'b1;
    for (int i = 0; i < 4; i++) expect_next(0, "wait_t1", 4'd2, E_T1, 4'd0, 1'b0);
    mem_ready = 1'b1; start_v[0] = 1'b0;
    expect_next(0, "add_t2", 4'd3, E_T2, 4'd0, 1'b0);
    expect_next(0, "add_t3", 4'd4, E_T3, 4'd0, 1'b0);
    expect_next(0, "add_t4", 4'd5, E_T4R, 4'd2, 1'b0);
    expect_next(0, "add_t5", 4'd6, E_T5, 4'd0, 1'b0);
    expect_next(0, "add_t0", 4'd1, E_T0, 4'd0, 1'b0);

    // halt opcode
    ir = IR_HALT;
    expect_next(0, "hlt_t1", 4'd2, E_T1, 4'd0, 1'b0);
    expect_next(0, "hlt_t2", 4'd3, E_T2, 4'd0, 1'b0);
    expect_next(0, "hlt_t3", 4'd4, E_0, 4'd0, 1'b0);
    expect_next(0, "hlt_halt", 4'd0, E_0, 4'd0, 1'b0);
    expect_next(0, "hlt_stay", 4'd0, E_0, 4'd0, 1'b0);

    // unknown opcode sets sticky illegal
    ir = IR_ILL; start_v[0] = 1'b1;
    expect_next(0, "ill_t0", 4'd1, E_T0, 4'd0, 1'b0);
    start_v[0] = 1'b0;
    expect_next(0, "ill_t1", 4'd2, E_T1, 4'd0, 1'b0);
    expect_next(0, "ill_t2", 4'd3, E_T2, 4'd0, 1'b0);
    expect_next(0, "ill_t3", 4'd4, E_0, 4'd0, 1'b0);
    expect_next(0, "ill_halt", 4'd0, E_0, 4'd0, 1'b1);
    expect_next(0, "ill_sticky", 4'd0, E_0, 4'd0, 1'b1);

    // start clears illegal; then reset during T4 of an or
    ir = IR_OR; start_v[0] = 1'b1;
    expect_next(0, "or_t0", 4'd1, E_T0, 4'd0, 1'b0);
    start_v[0] = 1'b0;
    expect_next(0, "or_t1", 4'd2, E_T1, 4'd0, 1'b0);
    expect_next(0, "or_t2", 4'd3, E_T2, 4'd0, 1'b0);
    expect_next(0, "or_t3", 4'd4, E_T3, 4'd0, 1'b0);
    expect_next(0, "or_t4", 4'd5, E_T4R, 4'd1, 1'b0);
    Clear = 1'b0;
    expect_next(0, "midrst", 4'd0, E_0, 4'd0, 1'b0);
    Clear = 1'b1;
    expect_next(0, "midrst_after", 4'd0, E_0, 4'd0, 1'b0);

    // mul: two-word writeback with the macro, illegal without
    ir = IR_MUL; start_v[0] = 1'b1;
    expect_next(0, "mul_t0", 4'd1, E_T0, 4'd0, 1'b0);
    start_v[0] = 1'b0;
    expect_next(0, "mul_t1", 4'd2, E_T1, 4'd0, 1'b0);
    expect_next(0, "mul_t2", 4'd3, E_T2, 4'd0, 1'b0);
`ifdef CTRL_SEQ_MULDIV_EN
    expect_next(0, "mul_t3", 4'd4, E_T3, 4'd0, 1'b0);
    expect_next(0, "mul_t4", 4'd5, E_T4M, 4'd4, 1'b0);
    expect_next(0, "mul_t5", 4'd6, E_T5M, 4'd0, 1'b0);
    expect_next(0, "mul_t6", 4'd7, E_T6, 4'd0, 1'b0);
    expect_next(0, "mul_t0b", 4'd1, E_T0, 4'd0, 1'b0);
`else
    expect_next(0, "mul_t3", 4'd4, E_0, 4'd0, 1'b0);
    expect_next(0, "mul_ill", 4'd0, E_0, 4'd0, 1'b1);
`endif

    // STEP_CYCLES=3 instance: add takes 18 clocks, every strobe held 3 cycles
    ir = IR_ADD; mem_ready = 1'b1; start_v[1] = 1'b1;
    for (int s = 0; s < 18; s++) begin
      expect_next(1, "add3", st3[s / 3], sb3[s / 3], c3[s / 3], 1'b0);
      start_v[1] = 1'b0;
    end
    expect_next(1, "add3_wrap", 4'd1, E_T0, 4'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
